// File: rtl/fir_out_decimator.sv
// Keeps every DECIM-th fir_filter sample, requantises it to OUT_W bits with
// round half-up and saturation, and queues it in a small FIFO for a valid/ready consumer.
module fir_out_decimator #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic signed [IN_W-1:0]      in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_W-1:0]     out_data,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] RND  = (SHIFT > 0) ? ((IN_W + 1)'(1) << RSH) : '0;
  localparam logic signed [IN_W:0] MAXV = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = ~MAXV;
  localparam logic [AW:0]          FULL = (AW + 1)'(DEPTH);

  logic [PH_W-1:0]          r_phase;
  logic                     w_keep;
  logic signed [IN_W:0]     w_ext;
  logic signed [IN_W:0]     w_sum;
  logic signed [IN_W:0]     w_shr;
  logic signed [OUT_W-1:0]  w_sat;
  logic                     r_stg_valid;
  logic signed [OUT_W-1:0]  r_stg_data;
  logic signed [OUT_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]            r_wr;
  logic [AW-1:0]            r_rd;
  logic [AW:0]              r_level;
  logic signed [OUT_W-1:0]  r_hold;
  logic                     r_overflow;
  logic [15:0]              r_drop_count;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_drop;

  assign w_keep = in_valid && (r_phase == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
    end else if (in_valid) begin
      r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + 1'b1;
    end
  end

  // One extra bit of headroom keeps the rounding add from wrapping at full scale.
  assign w_ext = {in_data[IN_W-1], in_data};
  assign w_sum = w_ext + RND;
  assign w_shr = w_sum >>> SHIFT;

  always_comb begin
    w_sat = w_shr[OUT_W-1:0];
    if (w_shr > MAXV) begin
      w_sat = MAXV[OUT_W-1:0];
    end else if (w_shr < MINV) begin
      w_sat = MINV[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
    end else begin
      r_stg_valid <= w_keep;
      if (w_keep) begin
        r_stg_data <= w_sat;
      end
    end
  end

  assign w_full = (r_level == FULL);
  assign w_pop  = out_valid && out_ready;
  assign w_push = r_stg_valid && (!w_full || w_pop);
  assign w_drop = r_stg_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= r_stg_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_level      <= '0;
      r_hold       <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_hold <= r_mem[r_rd];
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end
    end
  end

  // When empty, out_data keeps showing the last sample handed downstream.
  assign out_valid  = (r_level != '0);
  assign out_data   = out_valid ? r_mem[r_rd] : r_hold;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator at DECIM=4, SHIFT=15, OUT_W=16, DEPTH=8.
// Inputs change 1 ns after each rising edge; outputs are read at that same point.
module tb_fir_out_decimator;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [31:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [3:0]         fifo_level;
  logic               overflow;
  logic [15:0]        drop_count;

  int total = 0;
  int bad   = 0;

  fir_out_decimator #(
    .IN_W(32), .OUT_W(16), .SHIFT(15), .DECIM(4), .DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'sd12345;
    reset     = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== 16'sd0) begin bad++; $display("[TB] FAIL reset_out_data got=%0d want=0", out_data); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL reset_fifo_level got=%0d want=0", fifo_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%0b want=0", overflow); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_drop_count got=%0d want=0", drop_count); end
  endtask

  task automatic test_rounding_saturation();
    logic signed [31:0] vin  [7] = '{32'sd32768, 32'sd16384, 32'sd16383, -32'sd16384, -32'sd16385,
                                     32'sh7FFFFFFF, 32'sh80000000};
    logic signed [15:0] vexp [7] = '{16'sd1, 16'sd1, 16'sd0, 16'sd0, -16'sd1, 16'sd32767, -16'sd32768};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      reset_dut();
      in_valid = 1'b1;
      in_data  = vin[i];
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL round_no_bypass[%0d] got=%0b want=0", i, out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL round_valid_t2[%0d] got=%0b want=1", i, out_valid); end
      total++; if (out_data !== vexp[i]) begin bad++; $display("[TB] FAIL round_data[%0d] got=%0d want=%0d", i, out_data, vexp[i]); end
    end
  endtask

  task automatic test_decimation();
    logic signed [15:0] got [$];
    logic signed [15:0] want [4] = '{16'sd0, 16'sd4, 16'sd8, 16'sd12};
    reset_dut();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k < 16);
      in_data  = (k < 16) ? (k <<< 15) : 32'sd0;
      if (out_valid) got.push_back(out_data);
      tick();
    end
    in_valid = 1'b0;
    total++; if (got.size() !== 4) begin bad++; $display("[TB] FAIL decim_count got=%0d want=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== want[i]) begin bad++; $display("[TB] FAIL decim_data[%0d] got=%0d want=%0d", i, got[i], want[i]); end
      end
    end
  endtask

  task automatic test_valid_gaps();
    logic signed [15:0] got [$];
    logic signed [15:0] want [3] = '{16'sd0, 16'sd4, 16'sd8};
    int n = 0;
    reset_dut();
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (c % 3 == 0) && (n < 12);
      in_data  = in_valid ? (n <<< 15) : 32'sh7FFF0000;
      if (in_valid) n++;
      if (out_valid) got.push_back(out_data);
      tick();
    end
    in_valid = 1'b0;
    total++; if (got.size() !== 3) begin bad++; $display("[TB] FAIL gaps_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== want[i]) begin bad++; $display("[TB] FAIL gaps_data[%0d] got=%0d want=%0d", i, got[i], want[i]); end
      end
    end
  endtask

  // Kept samples carry values 1..nkept; filler samples in between are ignored.
  task automatic push_kept(input int nkept);
    for (int idx = 0; idx < nkept * 4; idx++) begin
      in_valid = 1'b1;
      in_data  = ((idx / 4) + 1) <<< 15;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_backpressure_overflow();
    logic signed [15:0] got [$];
    reset_dut();
    out_ready = 1'b0;
    push_kept(9);
    total++; if (fifo_level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=8", fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%0b want=1", overflow); end
    total++; if (drop_count !== 16'd1) begin bad++; $display("[TB] FAIL ovf_drop_count got=%0d want=1", drop_count); end
    total++; if (out_valid !== 1'b1 || out_data !== 16'sd1) begin bad++; $display("[TB] FAIL ovf_head_held got=%0b/%0d want=1/1", out_valid, out_data); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) got.push_back(out_data);
      tick();
    end
    total++; if (got.size() !== 8) begin bad++; $display("[TB] FAIL drain_count got=%0d want=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== 16'(i + 1)) begin bad++; $display("[TB] FAIL drain_data[%0d] got=%0d want=%0d", i, got[i], i + 1); end
      end
    end
    total++; if (fifo_level !== 4'd0 || out_data !== 16'sd8) begin bad++; $display("[TB] FAIL drain_final got=%0d/%0d want=0/8", fifo_level, out_data); end
  endtask

  task automatic test_reset_midrun();
    reset_dut();
    out_ready = 1'b0;
    push_kept(9);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    total++; if (fifo_level !== 4'd5) begin bad++; $display("[TB] FAIL mid_level_before got=%0d want=5", fifo_level); end
    in_valid = 1'b1;
    in_data  = 32'sd99 <<< 15;
    tick();
    reset = 1'b1;
    in_data = 32'sd55 <<< 15;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid got=%0b want=0", out_valid); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL mid_level_after got=%0d want=0", fifo_level); end
    total++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin bad++; $display("[TB] FAIL mid_overflow got=%0b/%0d want=0/0", overflow, drop_count); end
    in_valid = 1'b1;
    in_data  = 32'sd7 <<< 15;
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 16'sd7) begin bad++; $display("[TB] FAIL mid_first_kept got=%0b/%0d want=1/7", out_valid, out_data); end
    total++; if (fifo_level !== 4'd1) begin bad++; $display("[TB] FAIL mid_first_level got=%0d want=1", fifo_level); end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_rounding_saturation();
    test_decimation();
    test_valid_gaps();
    test_backpressure_overflow();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
